// File: rtl/alu_issue_stage.sv
// In-order ALU issue stage: RAW scoreboard, operand select and registered issue payload.
// Optional writeback-to-issue bypass is enabled by defining BYPASS_WB_EN.
module alu_issue_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_dec_valid,
  output logic                 o_dec_ready,
  input  logic [2*XLEN+21:0]   i_dec_uop,
  output logic [4:0]           o_rf_rs1_addr,
  output logic [4:0]           o_rf_rs2_addr,
  input  logic [XLEN-1:0]      i_rf_rs1_data,
  input  logic [XLEN-1:0]      i_rf_rs2_data,
  input  logic                 i_wb_valid,
  input  logic [4:0]           i_wb_rd,
  input  logic [XLEN-1:0]      i_wb_data,
  input  logic                 i_stall,
  input  logic                 i_flush,
  output logic                 o_m_valid,
  output logic [2*XLEN+21:0]   o_m_uop,
  output logic [XLEN-1:0]      o_m_op1,
  output logic [XLEN-1:0]      o_m_op2,
  output logic [NREG-1:0]      o_busy
);

  // uop layout (MSB..LSB): alu_op[3:0], rd_we, use_pc, use_imm, rd, rs1, rs2, pc, imm
  localparam int P_RS2  = 2*XLEN;
  localparam int P_RS1  = 2*XLEN + 5;
  localparam int P_RD   = 2*XLEN + 10;
  localparam int P_UIMM = 2*XLEN + 15;
  localparam int P_UPC  = 2*XLEN + 16;
  localparam int P_RDWE = 2*XLEN + 17;

  logic [4:0]        rs1_s, rs2_s, rd_s;
  logic              rd_we_s, use_pc_s, use_imm_s;
  logic [XLEN-1:0]   pc_s, imm_s;
  logic              byp1_s, byp2_s;
  logic              haz1_s, haz2_s, hazard_s, accept_s;
  logic [XLEN-1:0]   rs1_val_s, rs2_val_s;

  logic [NREG-1:0]   busy_q, busy_d;
  logic              m_valid_q, m_valid_d;
  logic [2*XLEN+21:0] m_uop_q, m_uop_d;
  logic [XLEN-1:0]   m_op1_q, m_op1_d, m_op2_q, m_op2_d;

  assign rs1_s     = i_dec_uop[P_RS1 +: 5];
  assign rs2_s     = i_dec_uop[P_RS2 +: 5];
  assign rd_s      = i_dec_uop[P_RD +: 5];
  assign rd_we_s   = i_dec_uop[P_RDWE];
  assign use_pc_s  = i_dec_uop[P_UPC];
  assign use_imm_s = i_dec_uop[P_UIMM];
  assign pc_s      = i_dec_uop[XLEN +: XLEN];
  assign imm_s     = i_dec_uop[0 +: XLEN];

  assign o_rf_rs1_addr = rs1_s;
  assign o_rf_rs2_addr = rs2_s;

`ifdef BYPASS_WB_EN
  assign byp1_s = i_wb_valid && (i_wb_rd == rs1_s) && (rs1_s != 5'd0);
  assign byp2_s = i_wb_valid && (i_wb_rd == rs2_s) && (rs2_s != 5'd0);
`else
  logic unused_wb_data_s;
  assign unused_wb_data_s = ^i_wb_data;
  assign byp1_s = 1'b0;
  assign byp2_s = 1'b0;
`endif

  // Hazard detection, handshake and operand selection
  always_comb begin
    haz1_s = (rs1_s != 5'd0) && busy_q[rs1_s] && !byp1_s;
    haz2_s = (rs2_s != 5'd0) && busy_q[rs2_s] && !byp2_s;
    hazard_s = i_dec_valid && (haz1_s || haz2_s);
    o_dec_ready = !i_stall && !hazard_s;
    accept_s = i_dec_valid && o_dec_ready;

    if (rs1_s == 5'd0) begin
      rs1_val_s = {XLEN{1'b0}};
    end else if (byp1_s) begin
      rs1_val_s = i_wb_data;
    end else begin
      rs1_val_s = i_rf_rs1_data;
    end

    if (rs2_s == 5'd0) begin
      rs2_val_s = {XLEN{1'b0}};
    end else if (byp2_s) begin
      rs2_val_s = i_wb_data;
    end else begin
      rs2_val_s = i_rf_rs2_data;
    end
  end

  // Scoreboard and output register next state; a same-cycle set beats the writeback clear
  always_comb begin
    busy_d    = busy_q;
    m_valid_d = m_valid_q;
    m_uop_d   = m_uop_q;
    m_op1_d   = m_op1_q;
    m_op2_d   = m_op2_q;

    if (i_flush) begin
      busy_d    = {NREG{1'b0}};
      m_valid_d = 1'b0;
      m_uop_d   = {(2*XLEN+22){1'b0}};
      m_op1_d   = {XLEN{1'b0}};
      m_op2_d   = {XLEN{1'b0}};
    end else begin
      if (i_wb_valid) begin
        busy_d[i_wb_rd] = 1'b0;
      end else begin
        busy_d = busy_d;
      end
      if (accept_s && rd_we_s && (rd_s != 5'd0)) begin
        busy_d[rd_s] = 1'b1;
      end else begin
        busy_d = busy_d;
      end
      busy_d[0] = 1'b0;

      if (i_stall) begin
        m_valid_d = m_valid_q;
      end else if (accept_s) begin
        m_valid_d = 1'b1;
        m_uop_d   = i_dec_uop;
        m_op1_d   = use_pc_s ? pc_s : rs1_val_s;
        m_op2_d   = use_imm_s ? imm_s : rs2_val_s;
      end else begin
        m_valid_d = 1'b0;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= {NREG{1'b0}};
      m_valid_q <= 1'b0;
      m_uop_q   <= {(2*XLEN+22){1'b0}};
      m_op1_q   <= {XLEN{1'b0}};
      m_op2_q   <= {XLEN{1'b0}};
    end else begin
      busy_q    <= busy_d;
      m_valid_q <= m_valid_d;
      m_uop_q   <= m_uop_d;
      m_op1_q   <= m_op1_d;
      m_op2_q   <= m_op2_d;
    end
  end

  assign o_m_valid = m_valid_q;
  assign o_m_uop   = m_uop_q;
  assign o_m_op1   = m_op1_q;
  assign o_m_op2   = m_op2_q;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage with a small register file model.
module tb_alu_issue_stage;

  localparam int UW = 86;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_dec_valid = 1'b0;
  logic          o_dec_ready;
  logic [UW-1:0] i_dec_uop = '0;
  logic [4:0]    o_rf_rs1_addr, o_rf_rs2_addr;
  logic [31:0]   i_rf_rs1_data, i_rf_rs2_data;
  logic          i_wb_valid = 1'b0;
  logic [4:0]    i_wb_rd = 5'd0;
  logic [31:0]   i_wb_data = 32'd0;
  logic          i_stall = 1'b0;
  logic          i_flush = 1'b0;
  logic          o_m_valid;
  logic [UW-1:0] o_m_uop;
  logic [31:0]   o_m_op1, o_m_op2;
  logic [31:0]   o_busy;

  logic [31:0]   rf [32];
  int            checks = 0;
  int            errors = 0;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n),
    .i_dec_valid(i_dec_valid), .o_dec_ready(o_dec_ready), .i_dec_uop(i_dec_uop),
    .o_rf_rs1_addr(o_rf_rs1_addr), .o_rf_rs2_addr(o_rf_rs2_addr),
    .i_rf_rs1_data(i_rf_rs1_data), .i_rf_rs2_data(i_rf_rs2_data),
    .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
    .i_stall(i_stall), .i_flush(i_flush),
    .o_m_valid(o_m_valid), .o_m_uop(o_m_uop), .o_m_op1(o_m_op1), .o_m_op2(o_m_op2),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  assign i_rf_rs1_data = rf[o_rf_rs1_addr];
  assign i_rf_rs2_data = rf[o_rf_rs2_addr];

  // Register file model: a writeback becomes readable from the next cycle
  always @(posedge clk) begin
    if (i_wb_valid) rf[i_wb_rd] <= i_wb_data;
  end

  function automatic logic [UW-1:0] mk(input logic [3:0] op, input logic we, input logic upc,
                                       input logic uimm, input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [31:0] pc, input logic [31:0] imm);
    return {op, we, upc, uimm, rd, rs1, rs2, pc, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (o_m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", o_m_valid); end
    checks++; if (o_busy !== 32'd0) begin errors++; $display("FAIL reset_busy got %h exp 0", o_busy); end
    checks++; if (o_m_uop !== '0) begin errors++; $display("FAIL reset_uop got %h exp 0", o_m_uop); end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_independent();
    i_dec_valid = 1'b1;
    i_dec_uop = mk(4'd0, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 32'h100, 32'd0);
    #1;
    checks++; if (o_dec_ready !== 1'b1) begin errors++; $display("FAIL ind_ready got %0b exp 1", o_dec_ready); end
    step();
    checks++; if (o_m_valid !== 1'b1 || o_m_op1 !== 32'd5 || o_m_op2 !== 32'd7)
      begin errors++; $display("FAIL ind_add got v=%0b %h/%h exp 1 5/7", o_m_valid, o_m_op1, o_m_op2); end
    i_dec_uop = mk(4'd0, 1'b1, 1'b0, 1'b1, 5'd4, 5'd0, 5'd0, 32'h104, 32'd9);
    step();
    checks++; if (o_m_valid !== 1'b1 || o_m_op1 !== 32'd0 || o_m_op2 !== 32'd9)
      begin errors++; $display("FAIL ind_addi got v=%0b %h/%h exp 1 0/9", o_m_valid, o_m_op1, o_m_op2); end
    checks++; if (o_busy !== 32'h12) begin errors++; $display("FAIL ind_busy got %h exp 12", o_busy); end
    i_dec_valid = 1'b0;
    i_wb_valid = 1'b1; i_wb_rd = 5'd1; i_wb_data = 32'd12;
    step();
    checks++; if (o_m_valid !== 1'b0) begin errors++; $display("FAIL ind_bubble got %0b exp 0", o_m_valid); end
    i_wb_rd = 5'd4; i_wb_data = 32'd9;
    step();
    i_wb_valid = 1'b0;
    checks++; if (o_busy !== 32'd0) begin errors++; $display("FAIL ind_clear got %h exp 0", o_busy); end
  endtask

  task automatic test_raw();
    i_dec_valid = 1'b1;
    i_dec_uop = mk(4'd0, 1'b1, 1'b0, 1'b0, 5'd5, 5'd2, 5'd3, 32'h0, 32'd0);
    step();
    checks++; if (o_busy !== 32'h20) begin errors++; $display("FAIL raw_set got %h exp 20", o_busy); end
    i_dec_uop = mk(4'd1, 1'b1, 1'b0, 1'b1, 5'd8, 5'd5, 5'd0, 32'h0, 32'd1);
    #1;
    checks++; if (o_dec_ready !== 1'b0) begin errors++; $display("FAIL raw_block got %0b exp 0", o_dec_ready); end
    step();
    checks++; if (o_m_valid !== 1'b0 || o_dec_ready !== 1'b0)
      begin errors++; $display("FAIL raw_wait got v=%0b r=%0b exp 0 0", o_m_valid, o_dec_ready); end
    i_wb_valid = 1'b1; i_wb_rd = 5'd5; i_wb_data = 32'h1234;
    #1;
`ifdef BYPASS_WB_EN
    checks++; if (o_dec_ready !== 1'b1) begin errors++; $display("FAIL raw_wb_ready got %0b exp 1", o_dec_ready); end
    step();
    i_wb_valid = 1'b0;
`else
    checks++; if (o_dec_ready !== 1'b0) begin errors++; $display("FAIL raw_wb_ready got %0b exp 0", o_dec_ready); end
    step();
    i_wb_valid = 1'b0;
    checks++; if (o_m_valid !== 1'b0) begin errors++; $display("FAIL raw_wb_bubble got %0b exp 0", o_m_valid); end
    #1;
    checks++; if (o_dec_ready !== 1'b1) begin errors++; $display("FAIL raw_after_ready got %0b exp 1", o_dec_ready); end
    step();
`endif
    checks++; if (o_m_valid !== 1'b1 || o_m_op1 !== 32'h1234 || o_m_op2 !== 32'd1)
      begin errors++; $display("FAIL raw_issue got v=%0b %h/%h exp 1 1234/1", o_m_valid, o_m_op1, o_m_op2); end
    i_dec_valid = 1'b0;
    i_wb_valid = 1'b1; i_wb_rd = 5'd8; i_wb_data = 32'h1235;
    step();
    i_wb_valid = 1'b0;
    checks++; if (o_busy !== 32'd0) begin errors++; $display("FAIL raw_clear got %h exp 0", o_busy); end
  endtask

  task automatic test_stall();
    logic [UW-1:0] c_uop;
    c_uop = mk(4'd2, 1'b1, 1'b0, 1'b0, 5'd9, 5'd2, 5'd3, 32'h200, 32'd0);
    i_dec_valid = 1'b1;
    i_dec_uop = c_uop;
    step();
    i_dec_uop = mk(4'd3, 1'b1, 1'b0, 1'b0, 5'd10, 5'd3, 5'd2, 32'h204, 32'd0);
    i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_wb_valid = (i == 0); i_wb_rd = 5'd9; i_wb_data = 32'h99;
      #1;
      checks++; if (o_dec_ready !== 1'b0) begin errors++; $display("FAIL stall_ready%0d got %0b exp 0", i, o_dec_ready); end
      step();
      checks++; if (o_m_valid !== 1'b1 || o_m_uop !== c_uop || o_m_op1 !== 32'd5 || o_m_op2 !== 32'd7)
        begin errors++; $display("FAIL stall_hold%0d got v=%0b %h/%h exp 1 5/7", i, o_m_valid, o_m_op1, o_m_op2); end
    end
    i_wb_valid = 1'b0;
    checks++; if (o_busy !== 32'd0) begin errors++; $display("FAIL stall_wbclear got %h exp 0", o_busy); end
    i_stall = 1'b0;
    step();
    checks++; if (o_m_valid !== 1'b1 || o_m_op1 !== 32'd7 || o_m_op2 !== 32'd5)
      begin errors++; $display("FAIL stall_resume got v=%0b %h/%h exp 1 7/5", o_m_valid, o_m_op1, o_m_op2); end
    i_dec_valid = 1'b0;
    i_wb_valid = 1'b1; i_wb_rd = 5'd10; i_wb_data = 32'd12;
    step();
    i_wb_valid = 1'b0;
  endtask

  task automatic test_flush();
    i_dec_valid = 1'b1;
    i_dec_uop = mk(4'd0, 1'b1, 1'b0, 1'b0, 5'd6, 5'd2, 5'd3, 32'h0, 32'd0);
    step();
    checks++; if (o_m_valid !== 1'b1 || o_busy !== 32'h40)
      begin errors++; $display("FAIL flush_pre got v=%0b busy=%h exp 1 40", o_m_valid, o_busy); end
    i_dec_valid = 1'b0;
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    checks++; if (o_m_valid !== 1'b0 || o_busy !== 32'd0 || o_m_op1 !== 32'd0)
      begin errors++; $display("FAIL flush_clear got v=%0b busy=%h op1=%h exp 0 0 0", o_m_valid, o_busy, o_m_op1); end
    i_dec_valid = 1'b1;
    i_dec_uop = mk(4'd0, 1'b0, 1'b0, 1'b0, 5'd12, 5'd6, 5'd0, 32'h0, 32'd0);
    #1;
    checks++; if (o_dec_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %0b exp 1", o_dec_ready); end
    step();
    checks++; if (o_m_valid !== 1'b1 || o_m_op1 !== 32'h66)
      begin errors++; $display("FAIL flush_issue got v=%0b op1=%h exp 1 66", o_m_valid, o_m_op1); end
  endtask

  task automatic test_x0_setclear();
    i_dec_valid = 1'b1;
    i_dec_uop = mk(4'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd2, 5'd3, 32'h0, 32'd0);
    step();
    checks++; if (o_busy !== 32'd0) begin errors++; $display("FAIL x0_busy got %h exp 0", o_busy); end
    i_dec_uop = mk(4'd0, 1'b1, 1'b0, 1'b0, 5'd7, 5'd2, 5'd3, 32'h0, 32'd0);
    step();
    checks++; if (o_busy !== 32'h80) begin errors++; $display("FAIL x7_set got %h exp 80", o_busy); end
    i_dec_uop = mk(4'd1, 1'b1, 1'b0, 1'b0, 5'd7, 5'd3, 5'd2, 32'h0, 32'd0);
    i_wb_valid = 1'b1; i_wb_rd = 5'd7; i_wb_data = 32'h77;
    step();
    i_wb_valid = 1'b0;
    checks++; if (o_busy !== 32'h80) begin errors++; $display("FAIL setclear got %h exp 80", o_busy); end
  endtask

  task automatic test_reset_mid();
    i_dec_valid = 1'b1;
    i_dec_uop = mk(4'd0, 1'b1, 1'b0, 1'b0, 5'd11, 5'd2, 5'd3, 32'h0, 32'd0);
    step();
    i_dec_valid = 1'b0;
    checks++; if (o_m_valid !== 1'b1 || o_busy !== 32'h880)
      begin errors++; $display("FAIL rstmid_pre got v=%0b busy=%h exp 1 880", o_m_valid, o_busy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (o_m_valid !== 1'b0 || o_busy !== 32'd0 || o_m_op1 !== 32'd0)
      begin errors++; $display("FAIL rstmid_async got v=%0b busy=%h op1=%h exp 0 0 0", o_m_valid, o_busy, o_m_op1); end
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rf[0] = 32'hdead_beef;
    rf[2] = 32'd5;
    rf[3] = 32'd7;
    rf[6] = 32'h66;
    test_reset();
    test_independent();
    test_raw();
    test_stall();
    test_flush();
    test_x0_setclear();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

In-order issue stage that drives the ALU side of `alu_issue_if`. It takes decoded uops from decode and reads rs1/rs2 from the register file. A 32-entry scoreboard blocks RAW hazards, and the stage presents registered `m_valid`/`m_uop`/`m_op1`/`m_op2` to `alu_stage`. It shares `i_stall`/`i_flush` with `alu_stage`, so both ends of the interface advance and hold on the same cycles.

## Interface
- XLEN, 32, operand width.
- NREG, 32, architectural registers; scoreboard depth.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- i_dec_valid  in  1  decode has a uop.
- o_dec_ready  out  1  stage accepts the uop this cycle.
- i_dec_uop  in  uop_t  decoded uop. Fields used: rs1, rs2, rd, rd_we, use_pc, use_imm, pc, imm, alu_op.
- o_rf_rs1_addr / o_rf_rs2_addr  out  5  register file read addresses; combinational from i_dec_uop.
- i_rf_rs1_data / i_rf_rs2_data  in  XLEN  register file read data; combinational.
- i_wb_valid  in  1  a writeback completes this cycle.
- i_wb_rd  in  5  writeback destination.
- i_wb_data  in  XLEN  writeback value.
- i_stall  in  1  downstream stall, the same signal `alu_stage` uses.
- i_flush  in  1  squash, the same signal `alu_stage` uses.
- issue_if  alu_issue_if.issue modport. The stage drives m_valid, m_uop, m_op1, m_op2.

## Operation
- Scoreboard: busy[NREG-1:0]. busy[0] is always 0.
- Hazard: `i_dec_valid && ((rs1!=0 && busy[rs1]) || (rs2!=0 && busy[rs2]))`, subject to the bypass exemption in Configuration.
- o_dec_ready = !i_stall && !hazard.
- accept = i_dec_valid && o_dec_ready.
- Operand select:
  - op1 = use_pc ? pc : rs1val.
  - op2 = use_imm ? imm : rs2val.
  - rsNval = 0 when rsN == 0; otherwise the register file data, or the bypass value when enabled.
- Scoreboard set: on accept with rd_we && rd != 0, busy[rd] is set.
- Scoreboard clear: i_wb_valid clears busy[i_wb_rd].
- Set and clear of the same rd in the same cycle: set wins, because the newly issued uop owns rd.
- Output register update:
  - i_flush: m_valid <= 0; m_uop, m_op1, m_op2 <= 0; busy <= 0. Writeback that cycle is ignored.
  - else i_stall: all outputs hold; no accept; scoreboard still clears on writeback.
  - else accept: m_valid <= 1 and the payload loads.
  - else: m_valid <= 0, a bubble. The payload may hold its old value.
- Flush source guarantees no older writeback is outstanding after the flush cycle.
- Reset: m_valid = 0, payload = 0, busy = 0.

## Timing
- Latency: a uop accepted at edge N appears on issue_if after edge N. `alu_stage` captures it at edge N+1 if not stalled.
- Throughput: one uop per cycle with no hazards.
- Decode must hold i_dec_uop stable while valid && !ready.
- o_dec_ready is combinational from i_stall, busy, and the current i_dec_uop. It has no dependency on i_dec_valid beyond the hazard term.
- A register written back at edge N is visible in the register file from cycle N+1. The scoreboard is clear from cycle N+1.
- Back-to-back dependency, rd of A = rs1 of B: B stalls until A's writeback.
- rst_n deassertion mid-stream: the first accept can happen in the first cycle after release.

## Configuration
- BYPASS_WB_EN defined:
  - If i_wb_valid && i_wb_rd == rsN && rsN != 0, rsN does not hazard that cycle.
  - rsNval = i_wb_data in that case. This saves one stall cycle per dependency.
- BYPASS_WB_EN undefined:
  - No bypass path.
  - busy[rs] blocks even during its writeback cycle; issue happens the next cycle from the register file.

## Test plan
- Independent ops: ADD x1=x2+x3 with x2=5, x3=7, then ADDI x4=x0+9, no stalls.
  - Required: m_valid high on consecutive cycles.
  - Required: m_op1/m_op2 = 5/7, then 0/9.
- RAW hazard: issue writes x5, next uop reads x5.
  - Required: o_dec_ready = 0 until writeback of x5 = 0x1234.
  - Required: dependent uop issues with m_op1 = 0x1234.
  - Issue lands on the writeback cycle when BYPASS_WB_EN is defined, one cycle later when it is undefined.
- Stall hold: assert i_stall for 3 cycles while m_valid = 1.
  - Required: m_uop/m_op1/m_op2 unchanged.
  - Required: o_dec_ready = 0.
  - Required: writeback during the stall still clears busy.
- Flush: busy[6] set, m_valid = 1, pulse i_flush.
  - Required: next cycle m_valid = 0 and busy = 0.
  - Required: a uop reading x6 issues immediately.
- x0 and same-cycle set/clear:
  - rd = x0 never sets busy.
  - Accept writing x7 in the same cycle as writeback of x7 leaves busy[7] = 1.
- Reset mid-operation: drop rst_n with m_valid = 1 and busy != 0.
  - Required: m_valid = 0 and busy = 0 immediately, asynchronously.
